regfile_scoreboard: RTL and testbench



---
 rtl/regfile_scoreboard_pkg.sv | 20 ++
 rtl/regfile_pend_ctr.sv | 52 +++++
 rtl/regfile_scoreboard.sv | 152 +++++++++++++++
 tb/tb_regfile_scoreboard.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults and constants for the register file scoreboard slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_scoreboard_pkg;

  localparam int DEF_NUM_RD = 4;
  localparam int DEF_NUM_WR = 2;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_PEND_W = 2;

  // Hard-wired zero register: reads 0, never written, never pending.
  localparam int REG_ZERO = 0;

  // Largest value a pending counter of width w can hold.
  function automatic int pend_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/regfile_pend_ctr.sv
// Pending-writer counter for one register; reports whether a requested alloc count fits.
// Latency: fit is combinational, the counter updates on the next rising clk.
// Backpressure: allocs are applied only when alloc_acc and fit are both high; writes never stall.
module regfile_pend_ctr
  import regfile_scoreboard_pkg::*;
#(
  parameter int PEND_W = DEF_PEND_W,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              flush,
  input  logic [CNT_W-1:0]  alloc_cnt,
  input  logic              alloc_acc,
  input  logic [CNT_W-1:0]  wr_cnt,
  output logic              fit,
  output logic [PEND_W-1:0] pend
);

  localparam int SUM_W = PEND_W + CNT_W;
  localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'(pend_max(PEND_W));

  logic [PEND_W-1:0] pend_q;
  logic [PEND_W-1:0] pend_d;
  logic [SUM_W-1:0]  with_alloc;
  logic [SUM_W-1:0]  base;

  assign pend = pend_q;

  // Fit check and next count: add accepted allocs, retire writes, clamp at zero, flush wins.
  always_comb begin
    with_alloc = SUM_W'(pend_q) + SUM_W'(alloc_cnt);
    fit        = (with_alloc <= PEND_MAX);
    base       = (alloc_acc && fit) ? with_alloc : SUM_W'(pend_q);
    pend_d     = '0;
    if (flush) begin
      pend_d = '0;
    end else if (base > SUM_W'(wr_cnt)) begin
      pend_d = PEND_W'(base - SUM_W'(wr_cnt));
    end
  end

  // Counter register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-ported register file with writeback bypass, per-register pending-writer scoreboard and HI/LO.
// Latency: reads, rd_ready and alloc_ready are combinational; writes and allocs commit on the next clk.
// Backpressure: alloc_ready low rejects every alloc in that cycle; writes and reads are never stalled.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WR = DEF_NUM_WR,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PEND_W = DEF_PEND_W
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR-1:0]        alloc_en,
  input  logic [NUM_WR*ADDR_W-1:0] alloc_addr,
  output logic                     alloc_ready,
  input  logic                     flush,
  input  logic                     hi_wen,
  input  logic                     lo_wen,
  input  logic [DATA_W-1:0]        hi_wdata,
  input  logic [DATA_W-1:0]        lo_wdata,
  output logic [DATA_W-1:0]        hi_rdata,
  output logic [DATA_W-1:0]        lo_rdata
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = $clog2(NUM_WR + 1);
  localparam int SUM_W = PEND_W + CNT_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [PEND_W-1:0] pend   [NREG];
  logic [NREG-1:0]   fit;
  logic [NUM_WR-1:0] wr_live;
  logic [NUM_WR-1:0] alloc_live;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // Ports aimed at the zero register are dropped before any other logic sees them.
  always_comb begin
    wr_live    = '0;
    alloc_live = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      wr_live[p]    = wr_en[p]    && (wr_addr[p*ADDR_W +: ADDR_W]    != ZERO_ADDR);
      alloc_live[p] = alloc_en[p] && (alloc_addr[p*ADDR_W +: ADDR_W] != ZERO_ADDR);
    end
  end

  // Data array commit: ports applied in program order so the youngest wins a collision.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_live[p]) begin
          regs_q[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Read ports: bypass youngest matching writeback, ready once every pending writer is here.
  always_comb begin : p_read
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;
    logic [CNT_W-1:0]  nmatch;
    rd_data  = '0;
    rd_ready = '0;
    ra       = '0;
    rdat     = '0;
    nmatch   = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra     = rd_addr[i*ADDR_W +: ADDR_W];
      rdat   = regs_q[ra];
      nmatch = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_live[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ra)) begin
          rdat   = wr_data[p*DATA_W +: DATA_W];
          nmatch = nmatch + CNT_W'(1);
        end
      end
      if (rd_en[i]) begin
        rd_data[i*DATA_W +: DATA_W] = rdat;
        rd_ready[i] = (pend[ra] == '0) || (SUM_W'(pend[ra]) == SUM_W'(nmatch));
      end
    end
  end

  assign pend[0] = '0;
  assign fit[0]  = 1'b1;

  for (genvar r = 1; r < NREG; r++) begin : g_pend
    logic [CNT_W-1:0] a_cnt;
    logic [CNT_W-1:0] w_cnt;

    // Count allocs and writebacks aimed at this register this cycle.
    always_comb begin
      a_cnt = '0;
      w_cnt = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (alloc_live[p] && (alloc_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          a_cnt = a_cnt + CNT_W'(1);
        end
        if (wr_live[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          w_cnt = w_cnt + CNT_W'(1);
        end
      end
    end

    regfile_pend_ctr #(
      .PEND_W(PEND_W),
      .CNT_W (CNT_W)
    ) u_ctr (
      .clk      (clk),
      .rst_     (rst_),
      .flush    (flush),
      .alloc_cnt(a_cnt),
      .alloc_acc(alloc_ready),
      .wr_cnt   (w_cnt),
      .fit      (fit[r]),
      .pend     (pend[r])
    );
  end

  // All-or-nothing: any register that would overflow blocks every alloc this cycle.
  assign alloc_ready = rst_ && (&fit);

  // HI/LO special registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_wen) hi_q <= hi_wdata;
      if (lo_wen) lo_q <= lo_wdata;
    end
  end

  assign hi_rdata = hi_wen ? hi_wdata : hi_q;
  assign lo_rdata = lo_wen ? lo_wdata : lo_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed vector table, reset/HI/LO sequence, random vs model.
// Latency: stimulus applied 1 time unit after the rising edge, outputs sampled 2 units later.
// Backpressure: alloc_ready is checked against the model's all-or-nothing capacity rule.
module tb_regfile_scoreboard;

  localparam int NR   = 4;
  localparam int NW   = 2;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;
  localparam int PMAX = 3;

  logic clk  = 1'b0;
  logic rst_ = 1'b1;

  logic [NR-1:0]    rd_en;
  logic [AW-1:0]    r_a [NR];
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_ready;
  logic [NW-1:0]    wr_en;
  logic [AW-1:0]    w_a [NW];
  logic [DW-1:0]    w_d [NW];
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NW-1:0]    alloc_en;
  logic [AW-1:0]    a_a [NW];
  logic [NW*AW-1:0] alloc_addr;
  logic             alloc_ready;
  logic             flush;
  logic             hi_wen, lo_wen;
  logic [DW-1:0]    hi_wdata, lo_wdata, hi_rdata, lo_rdata;

  assign rd_addr    = {r_a[3], r_a[2], r_a[1], r_a[0]};
  assign wr_addr    = {w_a[1], w_a[0]};
  assign wr_data    = {w_d[1], w_d[0]};
  assign alloc_addr = {a_a[1], a_a[0]};

  regfile_scoreboard dut (
    .clk        (clk),
    .rst_       (rst_),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .alloc_ready(alloc_ready),
    .flush      (flush),
    .hi_wen     (hi_wen),
    .lo_wen     (lo_wen),
    .hi_wdata   (hi_wdata),
    .lo_wdata   (lo_wdata),
    .hi_rdata   (hi_rdata),
    .lo_rdata   (lo_rdata)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle();
    rd_en = '0; wr_en = '0; alloc_en = '0; flush = 1'b0;
    hi_wen = 1'b0; lo_wen = 1'b0; hi_wdata = '0; lo_wdata = '0;
    for (int i = 0; i < NR; i++) r_a[i] = '0;
    for (int p = 0; p < NW; p++) begin
      w_a[p] = '0; w_d[p] = '0; a_a[p] = '0;
    end
  endtask

  task automatic do_reset();
    idle();
    rst_ = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        fl;
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [1:0]  ae;
    logic [4:0]  aa0;
    logic [4:0]  aa1;
    logic [4:0]  ra;
    logic [31:0] exp_d;
    logic        exp_rdy;
    logic        exp_ardy;
  } vec_t;

  function automatic vec_t v(input logic fl, input logic [1:0] we,
                             input logic [4:0] wa0, input logic [31:0] wd0,
                             input logic [4:0] wa1, input logic [31:0] wd1,
                             input logic [1:0] ae, input logic [4:0] aa0, input logic [4:0] aa1,
                             input logic [4:0] ra, input logic [31:0] ed,
                             input logic er, input logic ea);
    vec_t t;
    t.fl = fl; t.we = we; t.wa0 = wa0; t.wd0 = wd0; t.wa1 = wa1; t.wd1 = wd1;
    t.ae = ae; t.aa0 = aa0; t.aa1 = aa1; t.ra = ra;
    t.exp_d = ed; t.exp_rdy = er; t.exp_ardy = ea;
    return t;
  endfunction

  vec_t tbl [$];

  // Reference model state.
  logic [31:0] m_regs [NREG];
  int          m_pend [NREG];
  logic [31:0] m_hi, m_lo;
  int          add_r  [NREG];
  int          wr_r   [NREG];

  initial begin
    logic [31:0] e_d;
    logic        e_r;
    logic        ok;
    int          n;
    int          nv;

    // fl we  wa0 wd0           wa1 wd1           ae    aa0 aa1 ra  exp_d         rdy ardy
    tbl.push_back(v(0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b00, 0, 0, 5, 32'h0,        1, 1));
    tbl.push_back(v(0, 2'b01, 5, 32'hA5A5A5A5, 0, 32'h0,        2'b00, 0, 0, 5, 32'hA5A5A5A5, 1, 1));
    tbl.push_back(v(0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b00, 0, 0, 5, 32'hA5A5A5A5, 1, 1));
    tbl.push_back(v(0, 2'b11, 3, 32'h11,       3, 32'h22,       2'b00, 0, 0, 3, 32'h22,       1, 1));
    tbl.push_back(v(0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b00, 0, 0, 3, 32'h22,       1, 1));
    tbl.push_back(v(0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b01, 7, 0, 7, 32'h0,        1, 1));
    tbl.push_back(v(0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b00, 0, 0, 7, 32'h0,        0, 1));
    tbl.push_back(v(0, 2'b01, 7, 32'h55,       0, 32'h0,        2'b00, 0, 0, 7, 32'h55,       1, 1));
    tbl.push_back(v(0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b00, 0, 0, 7, 32'h55,       1, 1));
    tbl.push_back(v(0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b01, 9, 0, 9, 32'h0,        1, 1));
    tbl.push_back(v(0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b01, 9, 0, 9, 32'h0,        0, 1));
    tbl.push_back(v(0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b01, 9, 0, 9, 32'h0,        0, 1));
    tbl.push_back(v(0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b11, 9, 9, 9, 32'h0,        0, 0));
    tbl.push_back(v(0, 2'b01, 9, 32'h99,       0, 32'h0,        2'b00, 0, 0, 9, 32'h99,       0, 1));
    tbl.push_back(v(0, 2'b11, 9, 32'h1,        9, 32'h2,        2'b00, 0, 0, 9, 32'h2,        1, 1));
    tbl.push_back(v(0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b00, 0, 0, 9, 32'h2,        1, 1));
    tbl.push_back(v(0, 2'b11, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 2'b11, 0, 0, 0, 32'h0,        1, 1));
    tbl.push_back(v(0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        1, 1));
    tbl.push_back(v(0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b11, 4, 4, 4, 32'h0,        1, 1));
    tbl.push_back(v(1, 2'b00, 0, 32'h0,        0, 32'h0,        2'b01, 4, 0, 4, 32'h0,        0, 1));
    tbl.push_back(v(0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b00, 0, 0, 4, 32'h0,        1, 1));
    tbl.push_back(v(0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b01, 4, 0, 4, 32'h0,        1, 1));
    tbl.push_back(v(0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b00, 0, 0, 4, 32'h0,        0, 1));

    idle();
    #1;
    do_reset();
    chk("reset hi_rdata", hi_rdata, 32'h0);
    chk("reset lo_rdata", lo_rdata, 32'h0);

    // Directed vectors, one table row per clock, read on port 0.
    for (int k = 0; k < tbl.size(); k++) begin
      idle();
      flush = tbl[k].fl;
      wr_en = tbl[k].we; w_a[0] = tbl[k].wa0; w_d[0] = tbl[k].wd0; w_a[1] = tbl[k].wa1; w_d[1] = tbl[k].wd1;
      alloc_en = tbl[k].ae; a_a[0] = tbl[k].aa0; a_a[1] = tbl[k].aa1;
      rd_en = 4'b0001; r_a[0] = tbl[k].ra;
      #2;
      chk($sformatf("vec%0d rd_data", k), rd_data[31:0], tbl[k].exp_d);
      chk($sformatf("vec%0d rd_ready", k), {31'b0, rd_ready[0]}, {31'b0, tbl[k].exp_rdy});
      chk($sformatf("vec%0d alloc_ready", k), {31'b0, alloc_ready}, {31'b0, tbl[k].exp_ardy});
      @(posedge clk);
      #1;
    end

    // HI/LO bypass and independence.
    idle();
    hi_wen = 1'b1; hi_wdata = 32'h1234;
    #2;
    chk("hi bypass", hi_rdata, 32'h1234);
    chk("lo untouched", lo_rdata, 32'h0);
    @(posedge clk); #1;
    idle();
    lo_wen = 1'b1; lo_wdata = 32'hBEEF;
    #2;
    chk("hi stored", hi_rdata, 32'h1234);
    chk("lo bypass", lo_rdata, 32'hBEEF);
    @(posedge clk); #1;

    // Asynchronous reset in mid-cycle with a write and alloc pending on the inputs.
    idle();
    wr_en = 2'b01; w_a[0] = 5; w_d[0] = 32'h77;
    alloc_en = 2'b01; a_a[0] = 6;
    rd_en = 4'b0011; r_a[0] = 5; r_a[1] = 3;
    #1 rst_ = 1'b0;
    #1;
    chk("async rst hi", hi_rdata, 32'h0);
    chk("async rst lo", lo_rdata, 32'h0);
    chk("rst alloc_ready", {31'b0, alloc_ready}, 32'h0);
    chk("rst bypass r5", rd_data[31:0], 32'h77);
    chk("rst cleared r3", rd_data[63:32], 32'h0);
    @(posedge clk); #1;
    idle();
    rst_ = 1'b1;
    @(posedge clk); #1;
    rd_en = 4'b0011; r_a[0] = 5; r_a[1] = 6;
    #1;
    chk("no write in rst", rd_data[31:0], 32'h0);
    chk("no alloc in rst", {31'b0, rd_ready[1]}, 32'h1);
    chk("alloc_ready after rst", {31'b0, alloc_ready}, 32'h1);
    @(posedge clk); #1;

    // Random traffic against the model.
    do_reset();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0; m_pend[r] = 0;
    end
    m_hi = '0; m_lo = '0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      rd_en = NR'($urandom);
      for (int i = 0; i < NR; i++) r_a[i] = AW'($urandom_range(0, 7));
      wr_en    = NW'($urandom);
      alloc_en = NW'($urandom);
      for (int p = 0; p < NW; p++) begin
        w_a[p] = AW'($urandom_range(0, 7));
        w_d[p] = $urandom;
        a_a[p] = AW'($urandom_range(0, 7));
      end
      flush    = ($urandom_range(0, 15) == 0);
      hi_wen   = 1'($urandom); hi_wdata = $urandom;
      lo_wen   = 1'($urandom); lo_wdata = $urandom;
      #2;

      // Reads: youngest live writer bypasses; ready when every outstanding writer arrives now.
      for (int i = 0; i < NR; i++) begin
        e_d = (r_a[i] == 0) ? 32'h0 : m_regs[r_a[i]];
        n = 0;
        for (int p = 0; p < NW; p++) begin
          if (wr_en[p] && w_a[p] != 0 && w_a[p] == r_a[i]) begin
            e_d = w_d[p];
            n++;
          end
        end
        e_r = (m_pend[r_a[i]] == 0) || (m_pend[r_a[i]] == n);
        if (!rd_en[i]) begin
          e_d = '0; e_r = 1'b0;
        end
        chk($sformatf("rnd%0d rd%0d data", cyc, i), rd_data[i*DW +: DW], e_d);
        chk($sformatf("rnd%0d rd%0d ready", cyc, i), {31'b0, rd_ready[i]}, {31'b0, e_r});
      end

      // Capacity: every register must absorb its allocs, else none are taken.
      for (int r = 0; r < NREG; r++) begin
        add_r[r] = 0; wr_r[r] = 0;
      end
      for (int p = 0; p < NW; p++) begin
        if (alloc_en[p] && a_a[p] != 0) add_r[a_a[p]]++;
        if (wr_en[p] && w_a[p] != 0) wr_r[w_a[p]]++;
      end
      ok = 1'b1;
      for (int r = 0; r < NREG; r++) begin
        if (m_pend[r] + add_r[r] > PMAX) ok = 1'b0;
      end
      chk($sformatf("rnd%0d alloc_ready", cyc), {31'b0, alloc_ready}, {31'b0, ok});
      chk($sformatf("rnd%0d hi", cyc), hi_rdata, hi_wen ? hi_wdata : m_hi);
      chk($sformatf("rnd%0d lo", cyc), lo_rdata, lo_wen ? lo_wdata : m_lo);

      // Advance the model to the post-edge state.
      for (int r = 0; r < NREG; r++) begin
        nv = m_pend[r] + (ok ? add_r[r] : 0) - wr_r[r];
        if (nv < 0) nv = 0;
        m_pend[r] = flush ? 0 : nv;
      end
      for (int p = 0; p < NW; p++) begin
        if (wr_en[p] && w_a[p] != 0) m_regs[w_a[p]] = w_d[p];
      end
      if (hi_wen) m_hi = hi_wdata;
      if (lo_wen) m_lo = lo_wdata;

      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
